// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : State encoding, counter width and helpers shared by dmem_responder.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = 4;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return |byte_off;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module   : dmem_array
// Brief    : Single-port word storage, synchronous write, combinational read.
// Revision : 1.0
// ============================================================================
module dmem_array #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = mem_q[idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : One-outstanding data-memory responder with fixed wait states.
// Revision : 1.0
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam bit              ZERO_LAT = (LATENCY == 0);
    localparam logic [CNT_W-1:0] LAT_M1  = ZERO_LAT ? '0 : CNT_W'(LATENCY - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              wr_q,    wr_d;
    logic [ADDR_W+1:0] addr_q,  addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic              w_acc_go;
    logic              w_acc_write;
    logic [ADDR_W+1:0] w_acc_addr;
    logic [31:0]       w_acc_wdata;
    logic              w_mis;
    logic              w_we;
    logic [31:0]       w_arr_rdata;
    logic              w_unused_addr;

    assign w_unused_addr = ^req_addr[31:ADDR_W+2];

    // With zero wait states the access happens on the accept edge, straight from the inputs.
    assign w_acc_go    = ZERO_LAT ? (state_q == ST_IDLE) && req_valid
                                  : (state_q == ST_WAIT) && (cnt_q == '0);
    assign w_acc_write = ZERO_LAT ? req_write                 : wr_q;
    assign w_acc_addr  = ZERO_LAT ? req_addr[ADDR_W+1:0]      : addr_q;
    assign w_acc_wdata = ZERO_LAT ? req_wdata                 : wdata_q;
    assign w_mis       = is_misaligned(w_acc_addr[1:0]);

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .idx   (w_acc_addr[ADDR_W+1:2]),
        .wdata (w_acc_wdata),
        .rdata (w_arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = req_wdata;
                    if (ZERO_LAT) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        resp_valid = (state_q == ST_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        // Reset gating keeps an abandoned store out of the array.
        w_we       = w_acc_go && w_acc_write && !w_mis && reset;
        rdata_d    = rdata_q;
        err_d      = err_q;
        if (w_acc_go) begin
            err_d   = w_mis;
            rdata_d = (w_acc_write || w_mis) ? '0 : w_arr_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder at LATENCY 2, 0 and 3.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int NDUT = 3;

    logic             clk = 1'b0;
    logic [NDUT-1:0]  rst_n, rv, rw, rdy, vld, er, bsy;
    logic [31:0]      ra  [NDUT];
    logic [31:0]      rwd [NDUT];
    logic [31:0]      rd  [NDUT];

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] mdl_mem   [NDUT][64];
    bit          mdl_known [NDUT][64];

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(64), .ADDR_W(6), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(rst_n[0]), .req_valid(rv[0]), .req_write(rw[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]), .req_ready(rdy[0]), .resp_valid(vld[0]),
        .resp_rdata(rd[0]), .resp_err(er[0]), .busy(bsy[0])
    );
    dmem_responder #(.DEPTH(64), .ADDR_W(6), .LATENCY(0)) u_dut1 (
        .clk(clk), .reset(rst_n[1]), .req_valid(rv[1]), .req_write(rw[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]), .req_ready(rdy[1]), .resp_valid(vld[1]),
        .resp_rdata(rd[1]), .resp_err(er[1]), .busy(bsy[1])
    );
    dmem_responder #(.DEPTH(64), .ADDR_W(6), .LATENCY(3)) u_dut2 (
        .clk(clk), .reset(rst_n[2]), .req_valid(rv[2]), .req_write(rw[2]),
        .req_addr(ra[2]), .req_wdata(rwd[2]), .req_ready(rdy[2]), .resp_valid(vld[2]),
        .resp_rdata(rd[2]), .resp_err(er[2]), .busy(bsy[2])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name, input int k);
        chk({name, "_ready"}, k, rdy[k], 1);
        chk({name, "_busy"},  k, bsy[k], 0);
        chk({name, "_valid"}, k, vld[k], 0);
    endtask

    // Issue one request, scramble the request inputs while it is in flight,
    // and check the fixed response schedule plus the response payload.
    task automatic do_req(input int k, input bit write, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input bit exp_err, input bit check_data);
        int lat = lat_of(k);
        chk("ready_before", k, rdy[k], 1);
        rv[k] = 1'b1; rw[k] = write; ra[k] = addr; rwd[k] = wdata;
        for (int c = 1; c <= lat + 1; c++) begin
            step();
            rv[k] = 1'($urandom); rw[k] = 1'($urandom); ra[k] = $urandom; rwd[k] = $urandom;
            chk("busy_inflight", k, bsy[k], 1);
            chk("ready_inflight", k, rdy[k], 0);
            chk("resp_valid_sched", k, vld[k], (c == lat + 1));
        end
        if (check_data) chk("resp_rdata", k, rd[k], exp_rdata);
        chk("resp_err", k, er[k], exp_err);
        step();
        rv[k] = 1'b0;
        chk_idle("after_resp", k);
        if (check_data) chk("rdata_hold", k, rd[k], exp_rdata);
    endtask

    task automatic mdl_note(input int k, input bit write, input logic [31:0] addr, input logic [31:0] wdata);
        int idx = int'((addr >> 2) % 32'd64);
        if (write && (addr % 4 == 0)) begin
            mdl_mem[k][idx]   = wdata;
            mdl_known[k][idx] = 1'b1;
        end
    endtask

    task automatic model_req(input int k, input bit write, input logic [31:0] addr, input logic [31:0] wdata);
        int          idx = int'((addr >> 2) % 32'd64);
        bit          mis = (addr % 4 != 0);
        logic [31:0] exp = '0;
        bit          chkd = 1'b1;
        if (!write && !mis) begin
            if (mdl_known[k][idx]) exp = mdl_mem[k][idx];
            else chkd = 1'b0;
        end
        do_req(k, write, addr, wdata, exp, mis, chkd);
        mdl_note(k, write, addr, wdata);
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
        tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,          32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0,          1'b0};
        tbl[3] = '{1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 32'h0,          1'b1};
        tbl[4] = '{1'b0, 32'h0000_0020, 32'h0,          32'h1111_2222, 1'b0};
        tbl[5] = '{1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0,          1'b0};
        tbl[6] = '{1'b0, 32'h0000_0000, 32'h0,          32'hA5A5_A5A5, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_0023, 32'h0,          32'h0,          1'b1};
        tbl[8] = '{1'b0, 32'hFFFF_FF10, 32'h0,          32'hDEAD_BEEF, 1'b0};

        for (int k = 0; k < NDUT; k++) begin
            ra[k] = '0; rwd[k] = '0;
            for (int i = 0; i < 64; i++) mdl_known[k][i] = 1'b0;
        end
        rst_n = '0; rv = '0; rw = '0;
        step();
        step();
        for (int k = 0; k < NDUT; k++) begin
            chk_idle("reset", k);
            chk("reset_rdata", k, rd[k], 32'h0);
            chk("reset_err", k, er[k], 0);
        end
        rst_n = '1;
        step();

        for (int i = 0; i < 9; i++) begin
            do_req(0, tbl[i].write, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err, 1'b1);
            mdl_note(0, tbl[i].write, tbl[i].addr, tbl[i].wdata);
        end

        // Reset during the response cycle drops resp_valid on the next edge.
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h10;
        step();
        rv[0] = 1'b0;
        step();
        step();
        chk("resp_before_reset", 0, vld[0], 1);
        rst_n[0] = 1'b0;
        step();
        chk_idle("reset_in_resp", 0);
        rst_n[0] = 1'b1;
        step();

        // Zero-latency instance: preload, then back-to-back loads held on req_valid.
        model_req(1, 1'b1, 32'h40, 32'h1234_5678);
        model_req(1, 1'b0, 32'h40, 32'h0);
        rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b2b_valid", 1, vld[1], 1);
            chk("b2b_ready_low", 1, rdy[1], 0);
            chk("b2b_rdata", 1, rd[1], 32'h1234_5678);
            step();
            chk("b2b_gap_valid", 1, vld[1], 0);
            chk("b2b_ready_high", 1, rdy[1], 1);
        end
        rv[1] = 1'b0;
        step();
        chk_idle("b2b_end", 1);

        // Reset and req_valid in the same cycle: the store must not land.
        rst_n[1] = 1'b0; rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 32'h40; rwd[1] = 32'h99;
        step();
        rv[1] = 1'b0; rst_n[1] = 1'b1;
        chk_idle("reset_with_req", 1);
        step();
        chk_idle("reset_with_req_after", 1);
        model_req(1, 1'b0, 32'h40, 32'h0);

        // Reset while the LATENCY=3 instance waits, in cycle 2 and in cycle 3.
        model_req(2, 1'b1, 32'h08, 32'h0BAD_F00D);
        for (int cyc = 2; cyc <= 3; cyc++) begin
            rv[2] = 1'b1; rw[2] = 1'b1; ra[2] = 32'h08; rwd[2] = 32'h55 + 32'(cyc);
            step();
            rv[2] = 1'b0;
            for (int c = 1; c < cyc; c++) step();
            chk("wait_busy", 2, bsy[2], 1);
            rst_n[2] = 1'b0;
            step();
            rst_n[2] = 1'b1;
            chk_idle("reset_in_wait", 2);
            chk("reset_in_wait_rdata", 2, rd[2], 32'h0);
            for (int c = 0; c < 4; c++) begin
                step();
                chk("no_pulse_after_reset", 2, vld[2], 0);
            end
            model_req(2, 1'b0, 32'h08, 32'h0);
        end

        // Randomized traffic against the memory model on every instance.
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 40; n++) begin
                bit          wr   = 1'($urandom);
                logic [31:0] addr = ($urandom & 32'hFFFF_FF00)
                                  | (32'($urandom_range(0, 15)) << 2)
                                  | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
                model_req(k, wr, addr, $urandom);
                repeat ($urandom_range(0, 2)) step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
